// File: rtl/uart_pkg.sv
// Shared types for the UART receive-history block: display state and drop counter helpers.
package uart_pkg;

  typedef enum logic {
    LIVE   = 1'b0,
    FROZEN = 1'b1
  } state_t;

  localparam int unsigned DROP_W = 16;

  // Saturating increment for the dropped-word counter
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == '1) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/uart_rx_history_if.sv
// Bundle of receive, control and display signals between the UART side and the history block.
interface uart_rx_history_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned NUM_VIEW  = 2
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_BITS-1:0]                rx_data;
  logic                                rx_valid;
  logic                                clear;
  logic                                freeze;
  logic                                scroll_up;
  logic                                scroll_down;
  logic [NUM_VIEW-1:0][DATA_BITS-1:0]  view_data;
  logic [NUM_VIEW-1:0]                 view_valid;
  logic [PTR_W-1:0]                    view_offset;
  logic [CNT_W-1:0]                    count;
  logic [DROP_W-1:0]                   drop_count;
  logic                                new_pulse;

  modport master (
    output rx_data, rx_valid, clear, freeze, scroll_up, scroll_down,
    input  view_data, view_valid, view_offset, count, drop_count, new_pulse
  );

  modport slave (
    input  rx_data, rx_valid, clear, freeze, scroll_up, scroll_down,
    output view_data, view_valid, view_offset, count, drop_count, new_pulse
  );

endinterface

// File: rtl/history_mem.sv
// Circular history storage: one synchronous write port, NUM_VIEW combinational read ports.
module history_mem #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned NUM_VIEW  = 2
) (
  input  logic                                      clock,
  input  logic                                      wr_en,
  input  logic [$clog2(DEPTH)-1:0]                  wr_addr,
  input  logic [DATA_BITS-1:0]                      wr_data,
  input  logic [NUM_VIEW-1:0][$clog2(DEPTH)-1:0]    rd_addr,
  output logic [NUM_VIEW-1:0][DATA_BITS-1:0]        rd_data
);

  logic [DATA_BITS-1:0] mem [DEPTH];

  // Contents are not reset; validity is tracked by the controller's count
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_VIEW; i++) begin
      rd_data[i] = mem[rd_addr[i]];
    end
  end

endmodule

// File: rtl/uart_rx_history.sv
// Receive-history controller: LIVE/FROZEN mode, write pointer, fill count, scroll offset and registered display slots.
import uart_pkg::*;

module uart_rx_history #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned NUM_VIEW  = 2
) (
  input logic              clock,
  input logic              reset_n,
  uart_rx_history_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  state_t                              state;
  state_t                              state_n;
  logic [PTR_W-1:0]                    wp;
  logic [PTR_W-1:0]                    wp_n;
  logic [PTR_W-1:0]                    off;
  logic [PTR_W-1:0]                    off_n;
  logic [CNT_W-1:0]                    cnt;
  logic [CNT_W-1:0]                    cnt_n;
  logic [DROP_W-1:0]                   drop;
  logic [DROP_W-1:0]                   drop_n;
  logic                                accept;
  logic                                discard;
  logic                                npulse;
  logic [NUM_VIEW-1:0][PTR_W-1:0]      rd_addr;
  logic [NUM_VIEW-1:0][DATA_BITS-1:0]  rd_data;
  logic [NUM_VIEW-1:0][DATA_BITS-1:0]  vdata;
  logic [NUM_VIEW-1:0][DATA_BITS-1:0]  vdata_n;
  logic [NUM_VIEW-1:0]                 vvalid;
  logic [NUM_VIEW-1:0]                 vvalid_n;

  history_mem #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH),
    .NUM_VIEW  (NUM_VIEW)
  ) u_mem (
    .clock   (clock),
    .wr_en   (accept),
    .wr_addr (wp),
    .wr_data (bus.rx_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Next-state for mode, pointer, count, offset and drop counter; clear overrides everything
  always_comb begin
    state_n = bus.freeze ? FROZEN : LIVE;
    accept  = (state == LIVE)   && bus.rx_valid && !bus.clear;
    discard = (state == FROZEN) && bus.rx_valid && !bus.clear;
    wp_n    = wp;
    cnt_n   = cnt;
    off_n   = off;
    drop_n  = drop;
    if (bus.clear) begin
      wp_n   = '0;
      cnt_n  = '0;
      off_n  = '0;
      drop_n = '0;
    end else begin
      if (accept) begin
        wp_n = wp + PTR_W'(1);
        if (cnt != CNT_W'(DEPTH)) begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      if (discard) begin
        drop_n = sat_inc(drop);
      end
      if (state == LIVE || state_n == LIVE) begin
        off_n = '0;
      end else if (bus.scroll_up && !bus.scroll_down &&
                   ((CNT_W'(off) + CNT_W'(1)) < cnt)) begin
        off_n = off + PTR_W'(1);
      end else if (bus.scroll_down && !bus.scroll_up && (off != '0)) begin
        off_n = off - PTR_W'(1);
      end
    end
  end

  // Storage address of the entry each slot will show after this edge
  always_comb begin
    rd_addr = '0;
    for (int unsigned i = 0; i < NUM_VIEW; i++) begin
      rd_addr[i] = wp_n - PTR_W'(1) - off_n - PTR_W'(i);
    end
  end

  // Slot contents; the word being written this cycle is forwarded so it shows at age 0 immediately
  always_comb begin
    vdata_n  = '0;
    vvalid_n = '0;
    for (int unsigned i = 0; i < NUM_VIEW; i++) begin
      if ((CNT_W'(off_n) + CNT_W'(i)) < cnt_n) begin
        vvalid_n[i] = 1'b1;
        vdata_n[i]  = (accept && (rd_addr[i] == wp)) ? bus.rx_data : rd_data[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= LIVE;
      wp     <= '0;
      cnt    <= '0;
      off    <= '0;
      drop   <= '0;
      npulse <= 1'b0;
      vdata  <= '0;
      vvalid <= '0;
    end else begin
      state  <= state_n;
      wp     <= wp_n;
      cnt    <= cnt_n;
      off    <= off_n;
      drop   <= drop_n;
      npulse <= accept;
      vdata  <= vdata_n;
      vvalid <= vvalid_n;
    end
  end

  assign bus.view_data   = vdata;
  assign bus.view_valid  = vvalid;
  assign bus.view_offset = off;
  assign bus.count       = cnt;
  assign bus.drop_count  = drop;
  assign bus.new_pulse   = npulse;

endmodule

// File: tb/tb_uart_rx_history.sv
// Scoreboard bench for uart_rx_history: accepted words are queued on issue and checked when new_pulse appears.
module tb_uart_rx_history;

  logic clock;
  logic reset_n;

  uart_rx_history_if #(.DATA_BITS(8), .DEPTH(16), .NUM_VIEW(2)) bus ();

  uart_rx_history #(
    .DATA_BITS (8),
    .DEPTH     (16),
    .NUM_VIEW  (2)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic [7:0] data;
    logic [4:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests  = 0;
  int   errors = 0;
  int   mcount = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every new_pulse must match the oldest queued accepted word
  always @(negedge clock) begin
    if (reset_n && bus.new_pulse) begin
      if (sb.size() == 0) begin
        tests++;
        errors++;
        $display("FAIL sb_unexpected_pulse: got new_pulse=1 slot0=%0h expected no pulse at %0t",
                 bus.view_data[0], $time);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_slot0", 32'(bus.view_data[0]), 32'(mon_e.data));
        chk("sb_count", 32'(bus.count), 32'(mon_e.cnt));
        chk("sb_valid0", 32'(bus.view_valid[0]), 32'd1);
        chk("sb_offset", 32'(bus.view_offset), 32'd0);
      end
    end
  end

  task automatic send(input logic [7:0] w, input bit acc);
    bus.rx_data  = w;
    bus.rx_valid = 1'b1;
    if (acc) begin
      mcount = (mcount < 16) ? mcount + 1 : 16;
      sb.push_back('{data: w, cnt: 5'(mcount)});
    end
    @(negedge clock);
    bus.rx_valid = 1'b0;
  endtask

  task automatic scroll(input bit up, input bit down);
    bus.scroll_up   = up;
    bus.scroll_down = down;
    @(negedge clock);
    bus.scroll_up   = 1'b0;
    bus.scroll_down = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    mcount    = 0;
    @(negedge clock);
    bus.clear = 1'b0;
  endtask

  task automatic set_freeze(input bit f);
    bus.freeze = f;
    @(negedge clock);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_count"},  32'(bus.count), 32'd0);
    chk({tag, "_valid"},  32'(bus.view_valid), 32'd0);
    chk({tag, "_data"},   32'(bus.view_data), 32'd0);
    chk({tag, "_offset"}, 32'(bus.view_offset), 32'd0);
    chk({tag, "_drop"},   32'(bus.drop_count), 32'd0);
    chk({tag, "_pulse"},  32'(bus.new_pulse), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset_n         = 1'b0;
    bus.rx_data     = '0;
    bus.rx_valid    = 1'b0;
    bus.clear       = 1'b0;
    bus.freeze      = 1'b0;
    bus.scroll_up   = 1'b0;
    bus.scroll_down = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Two words in LIVE
    send(8'h41, 1'b1);
    send(8'h42, 1'b1);
    chk("two_slot0", 32'(bus.view_data[0]), 32'h42);
    chk("two_slot1", 32'(bus.view_data[1]), 32'h41);
    chk("two_count", 32'(bus.count), 32'd2);
    chk("two_valid", 32'(bus.view_valid), 32'b11);

    // Wrap: 20 words into 16 entries
    do_clear();
    for (int w = 0; w < 20; w++) send(8'(w), 1'b1);
    chk("wrap_count", 32'(bus.count), 32'd16);
    chk("wrap_slot0", 32'(bus.view_data[0]), 32'h13);
    chk("wrap_slot1", 32'(bus.view_data[1]), 32'h12);
    set_freeze(1'b1);
    for (int k = 0; k < 15; k++) scroll(1'b1, 1'b0);
    chk("wrap_off15", 32'(bus.view_offset), 32'd15);
    chk("wrap_oldest", 32'(bus.view_data[0]), 32'h04);
    chk("wrap_valid_edge", 32'(bus.view_valid), 32'b01);
    chk("wrap_slot1_zero", 32'(bus.view_data[1]), 32'h00);
    scroll(1'b1, 1'b0);
    chk("wrap_off_clamp", 32'(bus.view_offset), 32'd15);
    set_freeze(1'b0);
    chk("wrap_release_off", 32'(bus.view_offset), 32'd0);
    chk("wrap_release_slot0", 32'(bus.view_data[0]), 32'h13);

    // Freeze with drops and scroll clamping
    do_clear();
    send(8'hA0, 1'b1);
    send(8'hA1, 1'b1);
    send(8'hA2, 1'b1);
    set_freeze(1'b1);
    for (int k = 0; k < 5; k++) send(8'hC0 + 8'(k), 1'b0);
    chk("frz_drop", 32'(bus.drop_count), 32'd5);
    chk("frz_count", 32'(bus.count), 32'd3);
    chk("frz_slot0", 32'(bus.view_data[0]), 32'hA2);
    for (int k = 0; k < 5; k++) scroll(1'b1, 1'b0);
    chk("frz_off_clamp", 32'(bus.view_offset), 32'd2);
    chk("frz_oldest", 32'(bus.view_data[0]), 32'hA0);
    chk("frz_valid_edge", 32'(bus.view_valid), 32'b01);
    scroll(1'b0, 1'b1);
    chk("frz_off1", 32'(bus.view_offset), 32'd1);
    chk("frz_off1_slot0", 32'(bus.view_data[0]), 32'hA1);
    chk("frz_off1_slot1", 32'(bus.view_data[1]), 32'hA0);
    scroll(1'b1, 1'b1);
    chk("frz_both_same", 32'(bus.view_offset), 32'd1);
    scroll(1'b0, 1'b1);
    scroll(1'b0, 1'b1);
    chk("frz_down_floor", 32'(bus.view_offset), 32'd0);
    scroll(1'b1, 1'b0);
    chk("frz_up_again", 32'(bus.view_offset), 32'd1);
    set_freeze(1'b0);
    chk("frz_release_off", 32'(bus.view_offset), 32'd0);
    chk("frz_release_slot0", 32'(bus.view_data[0]), 32'hA2);
    chk("frz_drop_kept", 32'(bus.drop_count), 32'd5);

    // Scroll in LIVE has no effect
    scroll(1'b1, 1'b0);
    chk("live_scroll", 32'(bus.view_offset), 32'd0);

    // Clear coincident with a word
    bus.rx_data  = 8'h55;
    bus.rx_valid = 1'b1;
    do_clear();
    bus.rx_valid = 1'b0;
    chk("clr_count", 32'(bus.count), 32'd0);
    chk("clr_valid", 32'(bus.view_valid), 32'd0);
    chk("clr_drop", 32'(bus.drop_count), 32'd0);
    chk("clr_pulse", 32'(bus.new_pulse), 32'd0);
    send(8'h66, 1'b1);
    chk("clr_next_slot0", 32'(bus.view_data[0]), 32'h66);
    chk("clr_next_count", 32'(bus.count), 32'd1);

    // Asynchronous reset mid-stream
    for (int k = 0; k < 8; k++) send(8'hB0 + 8'(k), 1'b1);
    chk("pre_rst_count", 32'(bus.count), 32'd9);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clock);
    reset_n = 1'b1;
    mcount  = 0;
    @(negedge clock);
    send(8'h77, 1'b1);
    chk("post_rst_slot0", 32'(bus.view_data[0]), 32'h77);
    chk("post_rst_count", 32'(bus.count), 32'd1);
    chk("post_rst_valid", 32'(bus.view_valid), 32'b01);

    repeat (3) @(negedge clock);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
